// File: rtl/touch_pkg.sv
// Shared types and default constants for the touch key debouncer.
// Holds the FSM state encoding and the default timing windows.
package touch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    LONG_HELD,
    DEB_RELEASE
  } state_t;

  // 20 ms debounce and 1 s long-press at 50 MHz
  localparam int DEF_DEB_CYCLES  = 1_000_000;
  localparam int DEF_LONG_CYCLES = 50_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Ports: clk, rst (async high), d (async in), q (synchronized out).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/touch_key_debounce.sv
// Touch key debouncer with press/release/short/long strobes.
// Ports: sys_clk, sys_rst (async high), touch_key (raw in),
//   key_level (debounced), press/release/short/long_pulse (1-cycle).
module touch_key_debounce
  import touch_pkg::*;
#(
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int LONG_CYCLES = DEF_LONG_CYCLES
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic touch_key,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse
);

  localparam int MAXC =
    (DEB_CYCLES > LONG_CYCLES) ? DEB_CYCLES : LONG_CYCLES;
  localparam int CW = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

  logic sk;

  sync_2ff u_sync (
    .clk (sys_clk),
    .rst (sys_rst),
    .d   (touch_key),
    .q   (sk)
  );

  state_t        state_q, state_d;
  logic [CW-1:0] deb_q, deb_d;
  logic [CW-1:0] hold_q, hold_d;
  logic          from_long_q, from_long_d;
  logic          key_d;
  logic          press_d, release_d;
  logic          short_d, long_d;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q       <= IDLE;
      deb_q         <= '0;
      hold_q        <= '0;
      from_long_q   <= 1'b0;
      key_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      state_q       <= state_d;
      deb_q         <= deb_d;
      hold_q        <= hold_d;
      from_long_q   <= from_long_d;
      key_level     <= key_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      short_pulse   <= short_d;
      long_pulse    <= long_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    deb_d       = deb_q;
    hold_d      = hold_q;
    from_long_d = from_long_q;
    key_d       = key_level;
    press_d     = 1'b0;
    release_d   = 1'b0;
    short_d     = 1'b0;
    long_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sk) begin
          state_d = DEB_PRESS;
          deb_d   = '0;
        end
      end
      DEB_PRESS: begin
        if (!sk) begin
          state_d = IDLE;
        end else if (deb_q == DEB_LAST) begin
          state_d = PRESSED;
          key_d   = 1'b1;
          press_d = 1'b1;
          hold_d  = '0;
        end else begin
          deb_d = deb_q + CW'(1);
        end
      end
      PRESSED: begin
        if (!sk) begin
          state_d     = DEB_RELEASE;
          deb_d       = '0;
          from_long_d = 1'b0;
        end else if (hold_q == LONG_LAST) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end else begin
          hold_d = hold_q + CW'(1);
        end
      end
      LONG_HELD: begin
        if (!sk) begin
          state_d     = DEB_RELEASE;
          deb_d       = '0;
          from_long_d = 1'b1;
        end
      end
      DEB_RELEASE: begin
        if (sk) begin
          // the return edge counts as a held cycle again
          state_d = from_long_q ? LONG_HELD : PRESSED;
          if (!from_long_q && hold_q < LONG_LAST)
            hold_d = hold_q + CW'(1);
        end else if (deb_q == DEB_LAST) begin
          state_d   = IDLE;
          key_d     = 1'b0;
          release_d = 1'b1;
          short_d   = !from_long_q;
        end else begin
          deb_d = deb_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
